piso_serializer: RTL and testbench
==================================

# piso_serializer

Parametrised parallel-in serial-out serializer with valid/ready load handshake, selectable bit order and shift-enable stall. It accepts a WIDTH-bit word, then emits it one bit per enabled clock on a serial lane with valid/last framing. Back-to-back words stream with no idle bit between them. It sits between a word-oriented producer and a bit-serial transmitter or line driver, and supersedes the fixed 4-bit shift register in the shift-register library.

## Interface
- WIDTH, 8: parallel word width in bits; legal range ≥ 2.
- MSB_FIRST, 0: bit order. 0 sends bit 0 first; 1 sends bit WIDTH-1 first.
- CNT_W (localparam), $clog2(WIDTH): bit-index counter width.

- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; asynchronous assert, active-low.
- data_i  input  WIDTH  parallel word.
- data_valid_i  input  1  producer holds a word on data_i.
- data_ready_o  output  1  serializer can accept a word this cycle.
- shift_en_i  input  1  advance one bit at this edge; 0 stalls the lane.
- serial_o  output  1  current serial bit.
- serial_valid_o  output  1  serial_o carries a frame bit.
- serial_last_o  output  1  serial_o is the final bit of the word.
- bit_idx_o  output  CNT_W  index within the frame of the bit being presented (0 = first bit sent).
- done_o  output  1  one-cycle pulse after the final bit of a word is consumed.

## Operation
- State machine with two states: IDLE and SHIFT. The registers are state, shift_reg[WIDTH-1:0], cnt[CNT_W-1:0] and done_q.
- Accept condition: data_valid_i && data_ready_o at a rising edge.
- data_ready_o is combinational:
  - 1 in IDLE.
  - 1 in SHIFT only when cnt == WIDTH-1 && shift_en_i == 1 (final bit being consumed).
  - 0 otherwise.
- IDLE:
  - On accept: shift_reg <= data_i, cnt <= 0, state <= SHIFT.
  - Otherwise the block holds.
- SHIFT with shift_en_i = 0: all registers hold, so serial_o, bit_idx_o and serial_last_o stay stable.
- SHIFT with shift_en_i = 1 and cnt < WIDTH-1:
  - cnt increments.
  - shift_reg shifts toward the output end: right with a zero fill at the MSB for MSB_FIRST = 0, left with a zero fill at the LSB for MSB_FIRST = 1.
- SHIFT with shift_en_i = 1 and cnt == WIDTH-1:
  - done_q <= 1.
  - If an accept occurs at the same edge: load the new word, cnt <= 0, stay in SHIFT.
  - Otherwise: state <= IDLE, shift_reg <= 0.
- Output decode:
  - serial_o = shift_reg[0] (MSB_FIRST = 0) or shift_reg[WIDTH-1] (MSB_FIRST = 1) while in SHIFT; forced to 0 in IDLE.
  - serial_valid_o = (state == SHIFT).
  - serial_last_o = SHIFT && cnt == WIDTH-1.
  - bit_idx_o = cnt.
- done_o = done_q. done_q is set only as described above and clears at the next edge unless it is set again.
- data_i is sampled only on accept. Changes to data_i at any other time have no effect.
- No bit is ever dropped or duplicated. Every enabled SHIFT cycle consumes exactly one bit.

## Timing
- Reset values (rst_ni low, asynchronous): state = IDLE, shift_reg = 0, cnt = 0, done_q = 0.
  - Outputs during and after reset: serial_o = 0, serial_valid_o = 0, serial_last_o = 0, bit_idx_o = 0, done_o = 0.
  - data_ready_o decodes to 1, but no accept occurs while rst_ni is low.
- Reset mid-frame aborts the word immediately, with no done_o pulse. The first edge after release behaves as IDLE.
- Latency:
  - Word accepted at edge N: first bit valid from just after edge N.
  - With shift_en_i held high, the last bit is presented after edge N+WIDTH-1.
  - done_o is high for the cycle following edge N+WIDTH.
- Throughput: 1 bit per enabled clock. Continuous valid with shift_en_i high gives a gapless stream of WIDTH-bit frames.
- Stall on the final bit: data_ready_o stays 0 and serial_last_o stays 1 until shift_en_i returns.

## Test plan
- Reset then single word, WIDTH = 8, MSB_FIRST = 0, data_i = 0xA5, shift_en_i = 1 -> serial_o is 1,0,1,0,0,1,0,1 over 8 cycles; serial_last_o only on the 8th; done_o one pulse on the 9th cycle; then IDLE with serial_valid_o = 0.
- Same word with MSB_FIRST = 1 -> serial_o is 1,0,1,0,0,1,0,1 reversed order check with 0x81 -> 1,0,0,0,0,0,0,1, and with 0x80 -> 1 then seven 0s.
- Back-to-back: 0x0F then 0xF0 with data_valid_i held high -> 16 consecutive valid bits, no gap; data_ready_o high only in IDLE and on bit 7 of frame 1; two done_o pulses, 8 cycles apart.
- Stall: toggle shift_en_i 1,0,0,1,... during 0x3C -> outputs frozen during 0 cycles; bit sequence unchanged; frame length equals 8 enabled edges.
- Reset asserted asynchronously at bit 3 of 0xFF -> all outputs 0 at once, with no done_o pulse; the next word 0x01 serializes cleanly.
- Producer pressure: data_valid_i high with changing data_i mid-frame -> only the word present at each accept edge is sent.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: valid/ready word load,
// one bit per enabled clock, valid/last framing, gapless streaming.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CNT_W    = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  input  logic             shift_en_i,
  output logic             serial_o,
  output logic             serial_valid_o,
  output logic             serial_last_o,
  output logic [CNT_W-1:0] bit_idx_o,
  output logic             done_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nx;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             at_last;
  logic             accept;

  assign at_last = (cnt_q == LAST);
  assign accept  = data_valid_i && data_ready_o;

  // Shifted word moves the next bit onto the output end
  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_nx = {shift_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign shift_nx = {1'b0, shift_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (shift_en_i && at_last && !accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_ready_o   = 1'b0;
    serial_o       = 1'b0;
    serial_valid_o = 1'b0;
    serial_last_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        data_ready_o = 1'b1;
      end
      SHIFT: begin
        data_ready_o   = at_last && shift_en_i;
        serial_valid_o = 1'b1;
        serial_last_o  = at_last;
        serial_o       = MSB_FIRST ? shift_q[WIDTH-1]
                                   : shift_q[0];
      end
      default: ;
    endcase
  end

  assign bit_idx_o = cnt_q;
  assign done_o    = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= data_i;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (shift_en_i) begin
            if (at_last) begin
              done_q <= 1'b1;
              if (accept) begin
                shift_q <= data_i;
                cnt_q   <= '0;
              end else begin
                shift_q <= '0;
              end
            end else begin
              shift_q <= shift_nx;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: LSB-first and MSB-first
// instances share stimulus; expected bits are queued at each accept.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic [W-1:0] data;
  logic         valid;
  logic         sen;

  logic         ready0, ser0, sv0, sl0, done0;
  logic [2:0]   idx0;
  logic         ready1, ser1, sv1, sl1, done1;
  logic [2:0]   idx1;

  bit q0[$];
  bit q1[$];
  bit exp_done;
  int checks;
  int failures;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .data_i         (data),
    .data_valid_i   (valid),
    .data_ready_o   (ready0),
    .shift_en_i     (sen),
    .serial_o       (ser0),
    .serial_valid_o (sv0),
    .serial_last_o  (sl0),
    .bit_idx_o      (idx0),
    .done_o         (done0)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .data_i         (data),
    .data_valid_i   (valid),
    .data_ready_o   (ready1),
    .shift_en_i     (sen),
    .serial_o       (ser1),
    .serial_valid_o (sv1),
    .serial_last_o  (sl1),
    .bit_idx_o      (idx1),
    .done_o         (done1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit er;
    bit acc;
    #1;
    er = (q0.size() == 0) || (q0.size() == 1 && sen);
    chk("ready", ready0, er);
    chk("ready_m", ready1, er);
    chk("valid", sv0, q0.size() != 0);
    chk("valid_m", sv1, q1.size() != 0);
    chk("last", sl0, q0.size() == 1);
    chk("last_m", sl1, q1.size() == 1);
    if (q0.size() != 0) begin
      chk("idx", idx0, W - q0.size());
      chk("idx_m", idx1, W - q1.size());
      chk("ser", ser0, q0[0]);
      chk("ser_m", ser1, q1[0]);
    end else begin
      chk("ser_idle", ser0, 0);
      chk("ser_idle_m", ser1, 0);
    end
    chk("done", done0, exp_done);
    chk("done_m", done1, exp_done);
    acc = valid && er;
    exp_done = sen && (q0.size() == 1);
    if (sen && q0.size() != 0) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        q0.push_back(data[i]);
        q1.push_back(data[W-1-i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    valid = 1'b1;
    data  = w;
    tick();
    valid = 1'b0;
    data  = '0;
    repeat (W + 2) tick();
  endtask

  task automatic chk_reset_outs();
    chk("rst_ser", ser0, 0);
    chk("rst_ser_m", ser1, 0);
    chk("rst_valid", sv0, 0);
    chk("rst_last", sl0, 0);
    chk("rst_idx", idx0, 0);
    chk("rst_done", done0, 0);
    chk("rst_done_m", done1, 0);
    chk("rst_ready", ready0, 1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_done = 1'b0;
    rst_ni   = 1'b0;
    valid    = 1'b0;
    sen      = 1'b1;
    data     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs();
    rst_ni = 1'b1;

    send(8'hA5);
    send(8'h81);
    send(8'h80);

    // back-to-back frames with valid held high
    valid = 1'b1;
    data  = 8'h0F;
    tick();
    data = 8'hF0;
    repeat (8) tick();
    valid = 1'b0;
    data  = '0;
    repeat (W + 2) tick();

    // stall pattern 1,0,0 during a frame
    valid = 1'b1;
    data  = 8'h3C;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      sen = (i % 3 == 0);
      tick();
    end
    sen = 1'b1;
    repeat (4) tick();

    // asynchronous reset in the middle of a frame
    valid = 1'b1;
    data  = 8'hFF;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b0;
    #2;
    chk_reset_outs();
    q0.delete();
    q1.delete();
    exp_done = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    send(8'h01);

    // producer pressure: data_i changes every cycle
    valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      data = W'($urandom);
      tick();
    end
    valid = 1'b0;
    repeat (W + 3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
